// File: rtl/pcie_io_mem_responder.sv
// -----------------------------------------------------------------------------
// pcie_io_mem_responder
//
// Memory-side responder for the PCIe endpoint I/O bridge request/response
// channel. Read and write request beats address a 2**ABITS byte on-chip SRAM
// organised as 64-bit words. Read data and one write acknowledge per write
// sequence come back through a small response FIFO.
//
// Build option:
//   PCIE_IO_MEM_WRPROT_EN  when defined, bytes 0x0000-0x00FF are read-only.
//                          Writes there are dropped and the ack reports fault.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   o_req_mem_ready      request beat may be accepted
//   i_req_mem_valid      request beat valid
//   i_req_mem_write      0 = read, 1 = write
//   i_req_mem_bytes      read byte count (0 means 1024)
//   i_req_mem_addr       byte address of the beat
//   i_req_mem_strob      write byte enables
//   i_req_mem_data       write data
//   i_req_mem_last       last beat of a write sequence
//   o_resp_mem_valid     response beat valid
//   o_resp_mem_last      last response of the sequence
//   o_resp_mem_fault     access error
//   o_resp_mem_addr      8-byte aligned address of the returned beat
//   o_resp_mem_data      read data (0 for write ack or faulted beat)
//   i_resp_mem_ready     consumer accepts response beat
//   o_dbg_state          current FSM state (IDLE=0, RD=1, WR=2, WACK=3)
//
// Handshake: on both channels a beat transfers on the rising edge where valid
// and ready are both high. The response outputs come straight from the FIFO
// head, so they cannot change while valid is high and ready is low.
// -----------------------------------------------------------------------------
module pcie_io_mem_responder #(
  parameter int ABITS      = 13,
  parameter int RESP_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_req_mem_ready,
  input  logic             i_req_mem_valid,
  input  logic             i_req_mem_write,
  input  logic [9:0]       i_req_mem_bytes,
  input  logic [ABITS-1:0] i_req_mem_addr,
  input  logic [7:0]       i_req_mem_strob,
  input  logic [63:0]      i_req_mem_data,
  input  logic             i_req_mem_last,
  output logic             o_resp_mem_valid,
  output logic             o_resp_mem_last,
  output logic             o_resp_mem_fault,
  output logic [ABITS-1:0] o_resp_mem_addr,
  output logic [63:0]      o_resp_mem_data,
  input  logic             i_resp_mem_ready,
  output logic [1:0]       o_dbg_state
);

  localparam int WW    = ABITS - 3;                 // word index width
  localparam int WORDS = 1 << WW;
  localparam int PW    = $clog2(RESP_DEPTH);        // FIFO pointer width
  localparam int CW    = $clog2(RESP_DEPTH + 1);    // FIFO occupancy width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    WACK = 2'd3
  } state_t;

  typedef struct packed {
    logic             last;
    logic             fault;
    logic [ABITS-1:0] addr;
    logic [63:0]      data;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   ready_en_q;          // holds request ready low until the first clock after reset

  // Read sequencer: next word to fetch (one spare bit marks overflow past the
  // top of memory) and number of beats still to be issued.
  logic [WW:0]      rd_word_q;
  logic [7:0]       rd_left_q;

  // One-deep read pipeline stage matching the synchronous SRAM latency.
  logic             rd_v_q;
  logic             rd_last_q;
  logic             rd_fault_q;
  logic [ABITS-1:0] rd_addr_q;

  // Write sequence tracking for the ack.
  logic [ABITS-1:0] wr_addr_q;
  logic             wr_fault_q;

  // SRAM
  logic [63:0] mem [WORDS];
  logic [63:0] mem_q;

  // Response FIFO
  resp_t          fifo_mem [RESP_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic          accept, pop, push, push_rd, push_ack, issue;
  logic          fifo_full, wr_beat, wr_prot;
  logic [7:0]    n_beats;
  logic [10:0]   bytes_eff;
  int            used;
  resp_t         push_entry, head;

  // ---------------------------------------------------------------------------
  // Request-side decode
  // ---------------------------------------------------------------------------
  assign accept    = i_req_mem_valid && o_req_mem_ready;
  assign fifo_full = (int'(count_q) == RESP_DEPTH);
  // Every beat accepted in WR belongs to the write sequence.
  assign wr_beat   = accept && ((state_q == WR) || i_req_mem_write);

  assign bytes_eff = (i_req_mem_bytes == 10'd0) ? 11'd1024 : {1'b0, i_req_mem_bytes};
  // ceil((addr[2:0] + bytes) / 8); at most 129 beats
  assign n_beats   = 8'(({8'd0, i_req_mem_addr[2:0]} + bytes_eff + 11'd7) >> 3);

`ifdef PCIE_IO_MEM_WRPROT_EN
  assign wr_prot = (i_req_mem_addr[ABITS-1:8] == '0);
`else
  assign wr_prot = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response-side flow control
  // ---------------------------------------------------------------------------
  assign pop = o_resp_mem_valid && i_resp_mem_ready;

  always_comb begin
    // Slots already spoken for: FIFO contents plus the read in flight,
    // minus the beat leaving this cycle. A read is only issued when its
    // data is certain to find a free slot when it arrives.
    used  = int'(count_q) + int'(rd_v_q) - int'(pop);
    issue = (state_q == RD) && (rd_left_q != 8'd0) && (used < RESP_DEPTH);
  end

  assign push_rd  = rd_v_q;
  // Pop-before-push lets the ack enter a full FIFO in the same cycle.
  assign push_ack = (state_q == WACK) && (!fifo_full || pop);
  assign push     = push_rd || push_ack;

  always_comb begin
    push_entry = '0;
    if (push_rd) begin
      push_entry.last  = rd_last_q;
      push_entry.fault = rd_fault_q;
      push_entry.addr  = rd_addr_q;
      push_entry.data  = rd_fault_q ? 64'd0 : mem_q;
    end else begin
      push_entry.last  = 1'b1;
      push_entry.fault = wr_fault_q;
      push_entry.addr  = wr_addr_q;
      push_entry.data  = 64'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and request ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    o_req_mem_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_req_mem_ready = ready_en_q;
        if (accept) begin
          if (!i_req_mem_write)    state_d = RD;
          else if (i_req_mem_last) state_d = WACK;
          else                     state_d = WR;
        end
      end
      RD: begin
        if (rd_v_q && rd_last_q) state_d = IDLE;
      end
      WR: begin
        o_req_mem_ready = ready_en_q && !fifo_full;
        if (accept && i_req_mem_last) state_d = WACK;
      end
      WACK: begin
        if (push_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      rd_word_q  <= '0;
      rd_left_q  <= '0;
      rd_v_q     <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_fault_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_fault_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;

      if (accept && (state_q == IDLE) && !i_req_mem_write) begin
        rd_word_q <= {1'b0, i_req_mem_addr[ABITS-1:3]};
        rd_left_q <= n_beats;
      end else if (issue) begin
        rd_word_q <= rd_word_q + (WW+1)'(1);
        rd_left_q <= rd_left_q - 8'd1;
      end

      rd_v_q <= issue;
      if (issue) begin
        rd_last_q  <= (rd_left_q == 8'd1);
        rd_fault_q <= rd_word_q[WW];
        // Overflowed beats report the low address bits; memory never wraps.
        rd_addr_q  <= {rd_word_q[WW-1:0], 3'b000};
      end

      if (wr_beat) begin
        if (state_q == IDLE) begin
          wr_addr_q  <= {i_req_mem_addr[ABITS-1:3], 3'b000};
          wr_fault_q <= wr_prot;
        end else begin
          wr_fault_q <= wr_fault_q || wr_prot;
        end
      end

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM (contents not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (wr_beat && !wr_prot) begin
      for (int i = 0; i < 8; i++) begin
        if (i_req_mem_strob[i])
          mem[i_req_mem_addr[ABITS-1:3]][8*i +: 8] <= i_req_mem_data[8*i +: 8];
      end
    end
    if (issue && !rd_word_q[WW])
      mem_q <= mem[rd_word_q[WW-1:0]];
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign head = fifo_mem[rd_ptr_q];

  // Outputs are forced to zero when empty so reset and idle look clean.
  assign o_resp_mem_valid = (count_q != '0);
  assign o_resp_mem_last  = o_resp_mem_valid && head.last;
  assign o_resp_mem_fault = o_resp_mem_valid && head.fault;
  assign o_resp_mem_addr  = o_resp_mem_valid ? head.addr : '0;
  assign o_resp_mem_data  = o_resp_mem_valid ? head.data : 64'd0;

endmodule

// File: tb/tb_pcie_io_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_pcie_io_mem_responder
//
// Directed bench for pcie_io_mem_responder. Driver tasks issue request beats
// and push the expected responses into exp_q; an independent monitor pops and
// compares every response beat the DUT hands over, and checks that a stalled
// beat holds its outputs.
// -----------------------------------------------------------------------------
module tb_pcie_io_mem_responder;

  localparam int EW     = 79;     // {last, fault, addr[12:0], data[63:0]}
  localparam int BUDGET = 400;

`ifdef PCIE_IO_MEM_WRPROT_EN
  localparam bit WRPROT = 1'b1;
  localparam logic [12:0] BASE = 13'h100;
`else
  localparam bit WRPROT = 1'b0;
  localparam logic [12:0] BASE = 13'h000;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_ready, req_valid, req_write, req_last;
  logic [9:0]  req_bytes;
  logic [12:0] req_addr;
  logic [7:0]  req_strob;
  logic [63:0] req_data;
  logic        resp_valid, resp_last, resp_fault, resp_ready;
  logic [12:0] resp_addr;
  logic [63:0] resp_data;
  logic [1:0]  dbg_state;

  pcie_io_mem_responder dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_req_mem_ready  (req_ready),
    .i_req_mem_valid  (req_valid),
    .i_req_mem_write  (req_write),
    .i_req_mem_bytes  (req_bytes),
    .i_req_mem_addr   (req_addr),
    .i_req_mem_strob  (req_strob),
    .i_req_mem_data   (req_data),
    .i_req_mem_last   (req_last),
    .o_resp_mem_valid (resp_valid),
    .o_resp_mem_last  (resp_last),
    .o_resp_mem_fault (resp_fault),
    .o_resp_mem_addr  (resp_addr),
    .o_resp_mem_data  (resp_data),
    .i_resp_mem_ready (resp_ready),
    .o_dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [63:0] model_mem [1024];
  bit          in_seq    = 1'b0;
  logic [12:0] seq_addr  = '0;
  bit          seq_fault = 1'b0;
  bit          toggle_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic last, input logic fault, input logic [12:0] addr,
                          input logic [63:0] data);
    exp_q.push_back({last, fault, addr, data});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic drive_beat(input logic wr, input logic [9:0] bytes, input logic [12:0] addr,
                            input logic [7:0] strob, input logic [63:0] data, input logic last);
    int t;
    req_valid = 1'b1;
    req_write = wr;
    req_bytes = bytes;
    req_addr  = addr;
    req_strob = strob;
    req_data  = data;
    req_last  = last;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < BUDGET) begin
      t++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout addr=%h waited=%0d cycles", addr, t);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic write_beat(input logic [12:0] addr, input logic [7:0] strob,
                            input logic [63:0] data, input logic last);
    bit prot;
    prot = WRPROT && (addr < 13'h100);
    if (!in_seq) begin
      in_seq    = 1'b1;
      seq_addr  = {addr[12:3], 3'b000};
      seq_fault = 1'b0;
    end
    seq_fault = seq_fault | prot;
    if (!prot) begin
      for (int i = 0; i < 8; i++)
        if (strob[i]) model_mem[addr[12:3]][8*i +: 8] = data[8*i +: 8];
    end
    if (last) begin
      push_exp(1'b1, seq_fault, seq_addr, 64'd0);
      in_seq = 1'b0;
    end
    drive_beat(1'b1, 10'd0, addr, strob, data, last);
  endtask

  // Read whose expected beats come from the bench memory model.
  task automatic read_model(input logic [12:0] addr, input logic [9:0] bytes);
    int n, w, b;
    b = (bytes == 10'd0) ? 1024 : int'(bytes);
    n = (int'(addr[2:0]) + b + 7) / 8;
    for (int k = 0; k < n; k++) begin
      w = int'(addr[12:3]) + k;
      if (w >= 1024) push_exp(k == n-1, 1'b1, 13'((w % 1024) * 8), 64'd0);
      else           push_exp(k == n-1, 1'b0, 13'(w * 8), model_mem[w]);
    end
    drive_beat(1'b0, bytes, addr, 8'h00, 64'd0, 1'b0);
  endtask

  // Read whose expected beats the caller has already pushed.
  task automatic read_exact(input logic [12:0] addr, input logic [9:0] bytes);
    drive_beat(1'b0, bytes, addr, 8'h00, 64'd0, 1'b0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * BUDGET) begin
      t++;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s outstanding=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every accepted response beat, check stall stability
  // ---------------------------------------------------------------------------
  initial begin
    logic [EW-1:0] got, exp, prev_beat;
    bit            prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      got = {resp_last, resp_fault, resp_addr, resp_data};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!resp_valid || got !== prev_beat) begin
            errors++;
            $display("FAIL stall_hold valid=%0b got=%h exp=%h", resp_valid, got, prev_beat);
          end
        end
        if (resp_valid && resp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got last=%0b fault=%0b addr=%h data=%h exp=none",
                     resp_last, resp_fault, resp_addr, resp_data);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp)
              begin
                errors++;
                $display("FAIL resp_beat got last=%0b fault=%0b addr=%h data=%h exp last=%0b fault=%0b addr=%h data=%h",
                         got[78], got[77], got[76:64], got[63:0],
                         exp[78], exp[77], exp[76:64], exp[63:0]);
              end
          end
        end
        prev_stall = resp_valid && !resp_ready;
        prev_beat  = got;
      end
    end
  end

  // Response-ready toggler for the backpressure test
  initial begin
    forever begin
      @(posedge clk);
      if (toggle_en) begin
        #1;
        resp_ready = ~resp_ready;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    req_valid = 1'b0; req_write = 1'b0; req_last = 1'b0;
    req_bytes = '0;   req_addr  = '0;   req_strob = '0; req_data = '0;
    resp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {63'd0, req_ready},  64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_last",  {63'd0, resp_last},  64'd0);
    chk("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
    chk("rst_resp_addr",  {51'd0, resp_addr},  64'd0);
    chk("rst_resp_data",  resp_data,           64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload words 0..159 as one multi-beat write sequence, then the top two words
    for (int i = 0; i < 160; i++)
      write_beat(13'(i * 8), 8'hFF, {32'hC0DE0000 + 32'(i), ~32'(i)}, i == 159);
    write_beat(13'h1FF0, 8'hFF, 64'h0BADF00D00003FE0, 1'b0);
    write_beat(13'h1FF8, 8'hFF, 64'h0BADF00D00003FF8, 1'b1);
    drain("preload");

    // Test 1: full-word write, read back with latency check
    write_beat(13'h100, 8'hFF, 64'h1122334455667788, 1'b1);
    drain("t1_write");
    push_exp(1'b1, 1'b0, 13'h100, 64'h1122334455667788);
    read_exact(13'h100, 10'd8);
    @(negedge clk);
    chk("t1_lat_edge0", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("t1_lat_edge1", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("t1_lat_edge2", {63'd0, resp_valid}, 64'd1);
    @(posedge clk); #1;
    drain("t1_read");

    // Test 2: partial strobe merge
    write_beat(13'h100, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b1);
    push_exp(1'b1, 1'b0, 13'h100, 64'h11223344BBBBBBBB);
    read_exact(13'h100, 10'd8);
    drain("t2");

    // Misaligned reads: 0x105+4 spans two words, BASE+7 single byte
    read_model(13'h105, 10'd4);
    read_model(BASE + 13'h7, 10'd1);
    read_model(BASE + 13'h3, 10'd13);
    drain("misaligned");

    // Test 3: read past top of memory, no wrap
    push_exp(1'b0, 1'b0, 13'h1FF0, 64'h0BADF00D00003FE0);
    push_exp(1'b0, 1'b0, 13'h1FF8, 64'h0BADF00D00003FF8);
    push_exp(1'b0, 1'b1, 13'h0000, 64'd0);
    push_exp(1'b1, 1'b1, 13'h0008, 64'd0);
    read_exact(13'h1FF0, 10'd32);
    drain("t3");

    // Test 4: 1024-byte read under toggling backpressure
    toggle_en = 1'b1;
    read_model(BASE, 10'd0);
    drain("t4");
    toggle_en = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;

    // Test 5: reset during beat 3 of an 8-beat read
    read_model(BASE, 10'd64);
    t = 0;
    @(negedge clk);
    while (!(resp_valid && resp_addr == BASE + 13'h10) && t < BUDGET) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (t >= BUDGET) begin
      errors++;
      $display("FAIL t5_beat3_timeout waited=%0d", t);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    chk("t5_edge_valid", {63'd0, resp_valid}, 64'd0);
    chk("t5_edge_last",  {63'd0, resp_last},  64'd0);
    chk("t5_edge_fault", {63'd0, resp_fault}, 64'd0);
    chk("t5_edge_addr",  {51'd0, resp_addr},  64'd0);
    chk("t5_edge_data",  resp_data,           64'd0);
    chk("t5_edge_ready", {63'd0, req_ready},  64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_partial", {63'd0, resp_valid}, 64'd0);
    end
    @(posedge clk); #1;
    read_model(13'h100, 10'd16);
    drain("t5_after");

    // Test 6: write into the low 256 bytes
    write_beat(13'h40, 8'hFF, 64'h000000000000DEAD, 1'b1);
    if (!WRPROT) begin
      push_exp(1'b1, 1'b0, 13'h40, 64'h000000000000DEAD);
      read_exact(13'h40, 10'd8);
    end
    drain("t6");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
